des_subkey_gen: RTL

Sequential DES key schedule. Accepts one 64-bit key and streams the 16 48-bit round subkeys, one per cycle, through a valid/ready handshake. Encryption order is K1..K16 using left rotations. Decryption order is K16..K1 using right rotations. It feeds the round datapath that drives the S-box stage, and is the reverse-direction counterpart needed for decryption.

---
 rtl/des_pkg.sv | 65 ++++++
 rtl/des_pc2.sv | 17 +
 rtl/des_subkey_gen.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule tables and helpers (FIPS 46-3 PC-1, PC-2, shift schedule).
// Tables hold FIPS 1-based bit positions; bit 1 is the MSB of the source word.
package des_pkg;

  localparam int unsigned HALF_W   = 32'd28;
  localparam int unsigned SUBKEY_W = 32'd48;
  localparam int unsigned ROUNDS   = 32'd16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [5:0] PC1_TAB [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  localparam logic [1:0] SHIFT_TAB [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // True when every byte of the key carries odd parity.
  function automatic logic key_parity_ok(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      ok = ok & (^k[b*8 +: 8]);
    end
    return ok;
  endfunction

  function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        n,
                                                 input logic              right);
    logic [HALF_W-1:0] r;
    case ({right, n})
      3'b001:  r = {x[26:0], x[27]};
      3'b010:  r = {x[25:0], x[27:26]};
      3'b101:  r = {x[0], x[27:1]};
      3'b110:  r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES PC-2 compression permutation: 56-bit C||D to 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] k_o
);

  // FIPS bit i of C||D lives at cd_i[56-i]; subkey bit j+1 at k_o[47-j].
  always_comb begin
    k_o = '0;
    for (int j = 0; j < 48; j++) begin
      k_o[6'(47 - j)] = cd_i[6'(7'd56 - {1'b0, PC2_TAB[6'(j)]})];
    end
  end

endmodule

// File: rtl/des_subkey_gen.sv
// Sequential DES key schedule streaming K1..K16 (encrypt) or K16..K1 (decrypt).
// Optional byte-parity check on the key is enabled by DES_SUBKEY_PARITY_CHK_EN.
module des_subkey_gen
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [1:64] key,
  input  logic        decrypt,
  output logic        sk_valid,
  input  logic        sk_ready,
  output logic [1:48] subkey,
  output logic [3:0]  sk_round,
  output logic        sk_last,
  output logic        key_perr
);

  state_e              state_q, state_d;
  logic [HALF_W-1:0]   c_q, c_d, d_q, d_d;
  logic [3:0]          step_q, step_d;
  logic [3:0]          round_q, round_d;
  logic                dir_q, dir_d;
  logic                perr_q, perr_d;

  logic [63:0]         key_s;
  logic [55:0]         pc1_s;
  logic [HALF_W-1:0]   c0_s, d0_s;
  logic                accept_s;
  logic                key_ok_s;
  logic                last_step_s;
  logic [1:0]          sh_s;
  logic [SUBKEY_W-1:0] pc2_s;

  assign key_s       = key;
  assign key_ready   = (state_q == ST_IDLE);
  assign accept_s    = key_valid & key_ready;
  assign last_step_s = (step_q == 4'(ROUNDS - 32'd1));

`ifdef DES_SUBKEY_PARITY_CHK_EN
  assign key_ok_s = key_parity_ok(key_s);
`else
  logic unused_par_s;
  assign key_ok_s     = 1'b1;
  assign unused_par_s = ^{key_s[56], key_s[48], key_s[40], key_s[32],
                          key_s[24], key_s[16], key_s[8],  key_s[0]};
`endif

  // PC-1 on the incoming key; FIPS bit i of the key is key_s[64-i].
  always_comb begin
    pc1_s = '0;
    for (int j = 0; j < 56; j++) begin
      pc1_s[6'(55 - j)] = key_s[6'(7'd64 - {1'b0, PC1_TAB[6'(j)]})];
    end
  end

  assign c0_s = pc1_s[55:28];
  assign d0_s = pc1_s[27:0];

  // Shift amount for the step after the current one; unused on the last step.
  always_comb begin
    sh_s = 2'd0;
    if (dir_q) begin
      sh_s = SHIFT_TAB[4'd15 - step_q];
    end else if (!last_step_s) begin
      sh_s = SHIFT_TAB[step_q + 4'd1];
    end else begin
      sh_s = 2'd0;
    end
  end

  // Next-state logic; decrypt starts from C0/D0 because C16/D16 equals C0/D0.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    step_d  = step_q;
    round_d = round_q;
    dir_d   = dir_q;
    perr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && key_ok_s) begin
          dir_d   = decrypt;
          step_d  = 4'd0;
          round_d = decrypt ? 4'd15 : 4'd0;
          if (decrypt) begin
            c_d = c0_s;
            d_d = d0_s;
          end else begin
            c_d = rot_half(c0_s, SHIFT_TAB[0], 1'b0);
            d_d = rot_half(d0_s, SHIFT_TAB[0], 1'b0);
          end
          state_d = ST_RUN;
        end else begin
          perr_d = accept_s & ~key_ok_s;
        end
      end
      ST_RUN: begin
        if (sk_ready) begin
          if (last_step_s) begin
            state_d = ST_IDLE;
          end else begin
            step_d  = step_q + 4'd1;
            round_d = dir_q ? (round_q - 4'd1) : (round_q + 4'd1);
            c_d     = rot_half(c_q, sh_s, dir_q);
            d_d     = rot_half(d_q, sh_s, dir_q);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and key-half registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      step_q  <= 4'd0;
      round_q <= 4'd0;
      dir_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      step_q  <= step_d;
      round_q <= round_d;
      dir_q   <= dir_d;
      perr_q  <= perr_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i ({c_q, d_q}),
    .k_o  (pc2_s)
  );

  assign subkey   = pc2_s;
  assign sk_valid = (state_q == ST_RUN);
  assign sk_last  = (state_q == ST_RUN) & last_step_s;
  assign sk_round = round_q;
  assign key_perr = perr_q;

endmodule
